// File: rtl/lut_neuron_pipe.sv
// lut_neuron_pipe: one neuron's truth table held in distributed RAM.
// The table is cleared by an init sweep, written through a config port, and
// read through a two-stage valid/ready pipeline that honours backpressure.
module lut_neuron_pipe #(
    parameter int FANIN    = 4,
    parameter int IN_BITS  = 2,
    parameter int OUT_BITS = 2,
    parameter int INIT_VAL = 0,
    localparam int AW      = FANIN * IN_BITS,
    localparam int DEPTH   = 1 << AW
) (
    input  logic                clk,
    input  logic                rst,
    input  logic [AW-1:0]       in_data,
    input  logic                in_valid,
    output logic                in_ready,
    output logic [OUT_BITS-1:0] out_data,
    output logic                out_valid,
    input  logic                out_ready,
    input  logic [AW-1:0]       cfg_addr,
    input  logic [OUT_BITS-1:0] cfg_data,
    input  logic                cfg_we,
    output logic                cfg_ready,
    input  logic                cfg_clear,
    output logic                init_done
);

    localparam logic [OUT_BITS-1:0] INIT_WORD = OUT_BITS'(INIT_VAL);

    typedef enum logic [1:0] {
        ST_INIT,
        ST_RUN,
        ST_DRAIN
    } state_t;

    state_t              state_q, state_d;
    logic [AW-1:0]       cnt_q, cnt_d;

    logic                s1_valid_q, s1_valid_d;
    logic [AW-1:0]       s1_addr_q, s1_addr_d;
    logic                s2_valid_q, s2_valid_d;
    logic [OUT_BITS-1:0] s2_data_q, s2_data_d;

    logic [OUT_BITS-1:0] mem [DEPTH];

    logic                mem_we;
    logic [AW-1:0]       mem_waddr;
    logic [OUT_BITS-1:0] mem_wdata;

    logic                advance1;
    logic                advance2;
    logic                accept;

    // Sweep, run and drain sequencing; the sweep counter wraps naturally at DEPTH.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        case (state_q)
            ST_INIT: begin
                cnt_d = cnt_q + AW'(1);
                if (&cnt_q) begin
                    state_d = ST_RUN;
                end
            end
            ST_RUN: begin
                if (cfg_clear) begin
                    state_d = ST_DRAIN;
                end
            end
            ST_DRAIN: begin
                if (!s1_valid_q && !s2_valid_q) begin
                    state_d = ST_INIT;
                    cnt_d   = '0;
                end
            end
            default: begin
                state_d = ST_INIT;
                cnt_d   = '0;
            end
        endcase
    end

    // Single table write port: the sweep owns it in INIT, the config port in RUN.
    always_comb begin
        mem_we    = 1'b0;
        mem_waddr = cfg_addr;
        mem_wdata = cfg_data;
        if (state_q == ST_INIT) begin
            mem_we    = 1'b1;
            mem_waddr = cnt_q;
            mem_wdata = INIT_WORD;
        end else if (state_q == ST_RUN) begin
            mem_we = cfg_we;
        end
    end

    // Pipeline handshake and stage updates; the table read sees pre-edge contents,
    // so a same-cycle write to the address being read returns the old entry.
    always_comb begin
        advance2   = !s2_valid_q || out_ready;
        advance1   = !s1_valid_q || advance2;
        in_ready   = (state_q == ST_RUN) && advance1;
        accept     = in_valid && in_ready;

        s1_valid_d = s1_valid_q;
        s1_addr_d  = s1_addr_q;
        s2_valid_d = s2_valid_q;
        s2_data_d  = s2_data_q;

        if (advance1) begin
            s1_valid_d = accept;
            if (accept) begin
                s1_addr_d = in_data;
            end
        end

        if (advance2) begin
            s2_valid_d = s1_valid_q;
            if (s1_valid_q) begin
                s2_data_d = mem[s1_addr_q];
            end
        end
    end

    // Control and pipeline registers; reset discards anything in flight.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= ST_INIT;
            cnt_q      <= '0;
            s1_valid_q <= 1'b0;
            s1_addr_q  <= '0;
            s2_valid_q <= 1'b0;
            s2_data_q  <= '0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            s1_valid_q <= s1_valid_d;
            s1_addr_q  <= s1_addr_d;
            s2_valid_q <= s2_valid_d;
            s2_data_q  <= s2_data_d;
        end
    end

    // Table storage, left unreset so it maps onto distributed RAM.
    always_ff @(posedge clk) begin
        if (mem_we) begin
            mem[mem_waddr] <= mem_wdata;
        end
    end

    assign out_data  = s2_data_q;
    assign out_valid = s2_valid_q;
    assign cfg_ready = (state_q == ST_RUN);
    assign init_done = (state_q == ST_RUN);

endmodule

// File: tb/tb_lut_neuron_pipe.sv
// tb_lut_neuron_pipe: directed checks of the LUT neuron pipeline, with a
// second instance covering the wider parameter set.
module tb_lut_neuron_pipe;

    typedef struct {
        logic [7:0] addr;
        logic [1:0] expected;
    } vec_t;

    logic       clk = 1'b0;
    logic       rst = 1'b1;

    logic [7:0] in_data;
    logic       in_valid;
    logic       in_ready;
    logic [1:0] out_data;
    logic       out_valid;
    logic       out_ready;
    logic [7:0] cfg_addr;
    logic [1:0] cfg_data;
    logic       cfg_we;
    logic       cfg_ready;
    logic       cfg_clear;
    logic       init_done;

    logic [8:0] in_data2;
    logic       in_valid2;
    logic       in_ready2;
    logic [3:0] out_data2;
    logic       out_valid2;
    logic       out_ready2;
    logic [8:0] cfg_addr2;
    logic [3:0] cfg_data2;
    logic       cfg_we2;
    logic       cfg_ready2;
    logic       cfg_clear2;
    logic       init_done2;

    int         assertions = 0;
    int         failures   = 0;

    logic [1:0] model [256];
    logic [1:0] sb [$];

    vec_t       reset_vecs [3];
    vec_t       load_vecs  [8];
    vec_t       clear_vecs [4];
    logic [8:0] p2_addrs   [3];

    lut_neuron_pipe dut (
        .clk       (clk),
        .rst       (rst),
        .in_data   (in_data),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .out_data  (out_data),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .cfg_addr  (cfg_addr),
        .cfg_data  (cfg_data),
        .cfg_we    (cfg_we),
        .cfg_ready (cfg_ready),
        .cfg_clear (cfg_clear),
        .init_done (init_done)
    );

    lut_neuron_pipe #(
        .FANIN    (3),
        .IN_BITS  (3),
        .OUT_BITS (4),
        .INIT_VAL (5)
    ) dut2 (
        .clk       (clk),
        .rst       (rst),
        .in_data   (in_data2),
        .in_valid  (in_valid2),
        .in_ready  (in_ready2),
        .out_data  (out_data2),
        .out_valid (out_valid2),
        .out_ready (out_ready2),
        .cfg_addr  (cfg_addr2),
        .cfg_data  (cfg_data2),
        .cfg_we    (cfg_we2),
        .cfg_ready (cfg_ready2),
        .cfg_clear (cfg_clear2),
        .init_done (init_done2)
    );

    // Free-running clock.
    always #5 clk = ~clk;

    // Watchdog so the run always terminates.
    initial begin
        #2000000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] watchdog expired");
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
        assertions++;
        if (actual !== expected) begin
            failures++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, actual, expected);
        end
    endtask

    // Single lookup on the default instance with an empty pipeline.
    task automatic applyStimulus(input logic [7:0] addr, input logic [1:0] expected, input string name);
        checkOutput({name, " in_ready"}, 32'(in_ready), 32'd1);
        in_valid = 1'b1;
        in_data  = addr;
        tick();
        in_valid = 1'b0;
        in_data  = 8'h00;
        checkOutput({name, " early out_valid"}, 32'(out_valid), 32'd0);
        tick();
        checkOutput({name, " out_valid"}, 32'(out_valid), 32'd1);
        checkOutput({name, " out_data"}, 32'(out_data), 32'(expected));
        tick();
    endtask

    task automatic cfgWrite(input logic [7:0] addr, input logic [1:0] data);
        cfg_we   = 1'b1;
        cfg_addr = addr;
        cfg_data = data;
        tick();
        cfg_we   = 1'b0;
        model[addr] = data;
    endtask

    function automatic logic [1:0] pattern(input logic [7:0] a);
        return a[1:0] ^ a[7:6];
    endfunction

    initial begin
        int         n;
        int         n1;
        int         n2;
        int         sent;
        int         got;
        int         first_out;
        int         last_out;
        int         accepted;
        int         drained;
        logic [7:0] next_addr;

        reset_vecs[0] = '{8'h00, 2'b00};
        reset_vecs[1] = '{8'h5A, 2'b00};
        reset_vecs[2] = '{8'hFF, 2'b00};

        load_vecs[0] = '{8'h00, 2'd0};
        load_vecs[1] = '{8'h5A, 2'd3};
        load_vecs[2] = '{8'hFF, 2'd0};
        load_vecs[3] = '{8'h81, 2'd3};
        load_vecs[4] = '{8'h40, 2'd1};
        load_vecs[5] = '{8'hC3, 2'd0};
        load_vecs[6] = '{8'h06, 2'd2};
        load_vecs[7] = '{8'h9D, 2'd3};

        clear_vecs[0] = '{8'h5A, 2'd0};
        clear_vecs[1] = '{8'h06, 2'd0};
        clear_vecs[2] = '{8'h40, 2'd0};
        clear_vecs[3] = '{8'hFF, 2'd0};

        p2_addrs[0] = 9'h000;
        p2_addrs[1] = 9'h0AB;
        p2_addrs[2] = 9'h1FF;

        in_data    = '0;
        in_valid   = 1'b0;
        out_ready  = 1'b1;
        cfg_addr   = '0;
        cfg_data   = '0;
        cfg_we     = 1'b0;
        cfg_clear  = 1'b0;
        in_data2   = '0;
        in_valid2  = 1'b0;
        out_ready2 = 1'b1;
        cfg_addr2  = '0;
        cfg_data2  = '0;
        cfg_we2    = 1'b0;
        cfg_clear2 = 1'b0;
        for (int i = 0; i < 256; i++) begin
            model[i] = 2'b00;
        end

        $display("[TB] reset state");
        rst = 1'b1;
        repeat (3) tick();
        checkOutput("reset out_valid", 32'(out_valid), 32'd0);
        checkOutput("reset out_data", 32'(out_data), 32'd0);
        checkOutput("reset in_ready", 32'(in_ready), 32'd0);
        checkOutput("reset cfg_ready", 32'(cfg_ready), 32'd0);
        checkOutput("reset init_done", 32'(init_done), 32'd0);

        $display("[TB] init sweep length");
        rst = 1'b0;
        n  = 0;
        n1 = -1;
        n2 = -1;
        while (n < 700 && (n1 < 0 || n2 < 0)) begin
            tick();
            n++;
            if (init_done && n1 < 0) n1 = n;
            if (init_done2 && n2 < 0) n2 = n;
        end
        checkOutput("sweep cycles default", 32'(n1), 32'd256);
        checkOutput("sweep cycles wide", 32'(n2), 32'd512);

        for (int i = 0; i < 3; i++) begin
            applyStimulus(reset_vecs[i].addr, reset_vecs[i].expected, $sformatf("reset vec %0d", i));
        end

        $display("[TB] wide parameter set reads");
        for (int i = 0; i < 3; i++) begin
            checkOutput($sformatf("wide %0d in_ready", i), 32'(in_ready2), 32'd1);
            in_valid2 = 1'b1;
            in_data2  = p2_addrs[i];
            tick();
            in_valid2 = 1'b0;
            tick();
            checkOutput($sformatf("wide %0d out_valid", i), 32'(out_valid2), 32'd1);
            checkOutput($sformatf("wide %0d out_data", i), 32'(out_data2), 32'd5);
            tick();
        end

        $display("[TB] table load");
        checkOutput("run cfg_ready", 32'(cfg_ready), 32'd1);
        for (int a = 0; a < 256; a++) begin
            cfgWrite(a[7:0], pattern(a[7:0]));
        end
        for (int i = 0; i < 8; i++) begin
            applyStimulus(load_vecs[i].addr, load_vecs[i].expected, $sformatf("load vec %0d", i));
        end

        $display("[TB] back-to-back stream");
        sb.delete();
        sent      = 0;
        got       = 0;
        first_out = -1;
        last_out  = -1;
        out_ready = 1'b1;
        for (int cyc = 0; cyc < 400 && got < 256; cyc++) begin
            in_valid = (sent < 256);
            in_data  = sent[7:0];
            if (out_valid) begin
                if (first_out < 0) first_out = cyc;
                last_out = cyc;
                checkOutput($sformatf("stream data %0d", got), 32'(out_data),
                            (sb.size() > 0) ? 32'(sb.pop_front()) : 32'hDEAD);
                got++;
            end
            if (in_valid && in_ready) begin
                sb.push_back(model[in_data]);
                sent++;
            end
            tick();
        end
        in_valid = 1'b0;
        checkOutput("stream result count", 32'(got), 32'd256);
        checkOutput("stream first result cycle", 32'(first_out), 32'd2);
        checkOutput("stream last result cycle", 32'(last_out), 32'd257);

        $display("[TB] backpressure");
        sb.delete();
        out_ready = 1'b0;
        next_addr = 8'h01;
        accepted  = 0;
        for (int cyc = 0; cyc < 5; cyc++) begin
            in_valid = 1'b1;
            in_data  = next_addr;
            if (out_valid) begin
                checkOutput($sformatf("bp hold data %0d", cyc), 32'(out_data),
                            (sb.size() > 0) ? 32'(sb[0]) : 32'hDEAD);
            end
            if (in_valid && in_ready) begin
                sb.push_back(model[next_addr]);
                next_addr++;
                accepted++;
            end
            tick();
        end
        checkOutput("bp accepted", 32'(accepted), 32'd2);
        checkOutput("bp in_ready low", 32'(in_ready), 32'd0);
        checkOutput("bp out_valid held", 32'(out_valid), 32'd1);
        in_valid  = 1'b0;
        out_ready = 1'b1;
        drained   = 0;
        for (int cyc = 0; cyc < 10 && sb.size() > 0; cyc++) begin
            if (out_valid) begin
                checkOutput($sformatf("bp drain data %0d", drained), 32'(out_data), 32'(sb.pop_front()));
                drained++;
            end
            tick();
        end
        checkOutput("bp drained", 32'(drained), 32'd2);
        checkOutput("bp no duplicate", 32'(out_valid), 32'd0);

        $display("[TB] read/write collision");
        cfgWrite(8'h40, 2'b10);
        checkOutput("collision in_ready", 32'(in_ready), 32'd1);
        in_valid = 1'b1;
        in_data  = 8'h40;
        tick();
        in_valid = 1'b0;
        cfg_we   = 1'b1;
        cfg_addr = 8'h40;
        cfg_data = 2'b01;
        tick();
        cfg_we = 1'b0;
        model[8'h40] = 2'b01;
        checkOutput("collision out_valid", 32'(out_valid), 32'd1);
        checkOutput("collision old data", 32'(out_data), 32'd2);
        tick();
        applyStimulus(8'h40, 2'b01, "collision new data");

        $display("[TB] clear with lookups in flight");
        checkOutput("clear accept0 in_ready", 32'(in_ready), 32'd1);
        in_valid = 1'b1;
        in_data  = 8'h5A;
        tick();
        checkOutput("clear accept1 in_ready", 32'(in_ready), 32'd1);
        in_data = 8'h06;
        tick();
        in_valid  = 1'b0;
        cfg_clear = 1'b1;
        checkOutput("clear first out_valid", 32'(out_valid), 32'd1);
        checkOutput("clear first out_data", 32'(out_data), 32'd3);
        tick();
        cfg_clear = 1'b0;
        checkOutput("drain in_ready", 32'(in_ready), 32'd0);
        checkOutput("drain cfg_ready", 32'(cfg_ready), 32'd0);
        checkOutput("drain init_done", 32'(init_done), 32'd0);
        checkOutput("clear second out_valid", 32'(out_valid), 32'd1);
        checkOutput("clear second out_data", 32'(out_data), 32'd2);
        tick();
        n = 1;
        checkOutput("drain empty out_valid", 32'(out_valid), 32'd0);
        while (n < 700 && !init_done) begin
            tick();
            n++;
        end
        checkOutput("clear to run cycles", 32'(n), 32'd258);
        for (int i = 0; i < 256; i++) begin
            model[i] = 2'b00;
        end
        for (int i = 0; i < 4; i++) begin
            applyStimulus(clear_vecs[i].addr, clear_vecs[i].expected, $sformatf("clear vec %0d", i));
        end

        $display("[TB] reset mid-stream");
        cfgWrite(8'h10, 2'b11);
        cfgWrite(8'h11, 2'b11);
        in_valid = 1'b1;
        in_data  = 8'h10;
        tick();
        in_data = 8'h11;
        tick();
        checkOutput("midreset pre out_valid", 32'(out_valid), 32'd1);
        checkOutput("midreset pre out_data", 32'(out_data), 32'd3);
        in_valid = 1'b0;
        rst      = 1'b1;
        #1;
        checkOutput("midreset out_valid", 32'(out_valid), 32'd0);
        checkOutput("midreset out_data", 32'(out_data), 32'd0);
        checkOutput("midreset in_ready", 32'(in_ready), 32'd0);
        checkOutput("midreset init_done", 32'(init_done), 32'd0);
        @(posedge clk);
        #1;
        rst = 1'b0;
        n = 0;
        while (n < 700 && !in_ready) begin
            tick();
            n++;
        end
        checkOutput("midreset sweep cycles", 32'(n), 32'd256);

        $display("End of test - %0d assertions evaluated, %0d failures", assertions, failures);
        $finish;
    end

endmodule
